// File: rtl/main_ram_arbiter.sv
// Round-robin arbiter and cycle sequencer for the asynchronous main RAM.
// One grant runs SETUP -> STROBE -> DONE, and every RAM pin comes straight from a flop.
module main_ram_arbiter #(
    parameter int unsigned ADDR_W = 20,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_ack,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_ack,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic              ram_cs_n,
    output logic              ram_oe_n,
    output logic              ram_w_n,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    typedef enum logic [1:0] {IDLE, SETUP, STROBE, DONE} state_e;
    typedef enum logic {PORT_A, PORT_B} port_e;

    state_e            state_q, state_d;
    port_e             last_q, last_d;
    logic              op_we_q, op_we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              cs_n_q, cs_n_d;
    logic              oe_n_q, oe_n_d;
    logic              w_n_q, w_n_d;
    logic              a_ack_q, a_ack_d;
    logic              b_ack_q, b_ack_d;
    logic              grant_b;

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        op_we_d = op_we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        grant_b = b_req && (!a_req || (last_q == PORT_A));

        case (state_q)
            IDLE: begin
                if (a_req || b_req) begin
                    state_d = SETUP;
                    last_d  = grant_b ? PORT_B : PORT_A;
                    op_we_d = grant_b ? b_we : a_we;
                    addr_d  = grant_b ? b_addr : a_addr;
                    wdata_d = grant_b ? b_wdata : a_wdata;
                end
            end
            SETUP:  state_d = STROBE;
            STROBE: begin
                state_d = DONE;
                if (!op_we_q) rdata_d = ram_rdata;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Strobes are decoded from the next state so each pin is a plain flop output.
        cs_n_d  = (state_d == IDLE);
        oe_n_d  = !(((state_d == SETUP) || (state_d == STROBE)) && !op_we_d);
        w_n_d   = !((state_d == STROBE) && op_we_d);
        a_ack_d = (state_d == DONE) && (last_d == PORT_A);
        b_ack_d = (state_d == DONE) && (last_d == PORT_B);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            last_q  <= PORT_B;
            op_we_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            cs_n_q  <= 1'b1;
            oe_n_q  <= 1'b1;
            w_n_q   <= 1'b1;
            a_ack_q <= 1'b0;
            b_ack_q <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            op_we_q <= op_we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            cs_n_q  <= cs_n_d;
            oe_n_q  <= oe_n_d;
            w_n_q   <= w_n_d;
            a_ack_q <= a_ack_d;
            b_ack_q <= b_ack_d;
        end
    end

    assign a_ack     = a_ack_q;
    assign b_ack     = b_ack_q;
    assign rdata     = rdata_q;
    assign busy      = (state_q != IDLE);
    assign ram_cs_n  = cs_n_q;
    assign ram_oe_n  = oe_n_q;
    assign ram_w_n   = w_n_q;
    assign ram_addr  = addr_q;
    assign ram_wdata = wdata_q;

endmodule

// File: tb/tb_main_ram_arbiter.sv
// Bench for main_ram_arbiter: asynchronous RAM model on the pins, plus an
// abstract memory/ordering model that predicts acks, latency and read data.
module tb_main_ram_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
    logic [19:0] a_addr = '0, b_addr = '0;
    logic [7:0]  a_wdata = '0, b_wdata = '0;
    logic        a_ack, b_ack, busy, ram_cs_n, ram_oe_n, ram_w_n;
    logic [7:0]  rdata, ram_wdata, ram_rdata;
    logic [19:0] ram_addr;

    int checks = 0;
    int failures = 0;

    logic [7:0] ref_mem [int unsigned];
    logic [7:0] exp_rd = 8'h00;

    logic [7:0] ram_mem [0:(1<<20)-1];

    main_ram_arbiter #(.ADDR_W(20), .DATA_W(8)) dut (
        .clk(clk), .reset(reset),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_ack(a_ack),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_ack(b_ack),
        .rdata(rdata), .busy(busy),
        .ram_cs_n(ram_cs_n), .ram_oe_n(ram_oe_n), .ram_w_n(ram_w_n),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < (1 << 20); i++) ram_mem[i] = 8'h00;
    end

    always @(negedge ram_w_n) begin
        if (!ram_cs_n) ram_mem[ram_addr] = ram_wdata;
    end

    assign ram_rdata = (!ram_cs_n && !ram_oe_n) ? ram_mem[ram_addr] : 8'hxx;

    function automatic logic [7:0] ref_rd(input logic [19:0] addr);
        return ref_mem.exists(int'(addr)) ? ref_mem[int'(addr)] : 8'h00;
    endfunction

    // Runs one access from an idle FSM, returning what was observed; starts and ends at a negedge.
    task automatic run_access(input bit pb, input bit we, input logic [19:0] addr, input logic [7:0] wd,
                              output int lat, output int wlow, output bit oe_wr, output bit bad_ack,
                              output logic [7:0] rd, output logic [19:0] addr_seen);
        lat = -1; wlow = 0; oe_wr = 1'b0; bad_ack = 1'b0; rd = '0; addr_seen = '0;
        if (pb) begin
            b_req = 1'b1; b_we = we; b_addr = addr; b_wdata = wd;
        end else begin
            a_req = 1'b1; a_we = we; a_addr = addr; a_wdata = wd;
        end
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (!ram_w_n) wlow++;
            if (we && !ram_oe_n) oe_wr = 1'b1;
            if (pb ? a_ack : b_ack) bad_ack = 1'b1;
            if (pb ? b_ack : a_ack) begin
                lat = c; rd = rdata; addr_seen = ram_addr;
                break;
            end
        end
        a_req = 1'b0; b_req = 1'b0;
        @(negedge clk);
        if (!ram_w_n) wlow++;
        if (a_ack || b_ack) bad_ack = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({ram_cs_n, ram_oe_n, ram_w_n, a_ack, b_ack, busy} !== 6'b111000) begin
            failures++;
            $display("FAIL reset_ctrl: got %b expected 111000", {ram_cs_n, ram_oe_n, ram_w_n, a_ack, b_ack, busy});
        end
        checks++;
        if ({rdata, ram_addr, ram_wdata} !== 36'h0) begin
            failures++;
            $display("FAIL reset_data: got rdata=%0h addr=%0h wdata=%0h expected all 0", rdata, ram_addr, ram_wdata);
        end
        reset = 1'b0;
        exp_rd = 8'h00;
    endtask

    task automatic test_a_write_read();
        int lat, wlow; bit oe_wr, bad; logic [7:0] rd; logic [19:0] as;
        run_access(1'b0, 1'b1, 20'h00010, 8'hA5, lat, wlow, oe_wr, bad, rd, as);
        ref_mem[32'h10] = 8'hA5;
        checks++;
        if (lat !== 3 || wlow !== 1 || oe_wr || bad) begin
            failures++;
            $display("FAIL a_write_timing: got lat=%0d wlow=%0d oe_wr=%0d bad_ack=%0d expected 3 1 0 0", lat, wlow, oe_wr, bad);
        end
        checks++;
        if (rd !== exp_rd) begin
            failures++;
            $display("FAIL a_write_rdata_hold: got %0h expected %0h", rd, exp_rd);
        end
        run_access(1'b0, 1'b0, 20'h00010, 8'h00, lat, wlow, oe_wr, bad, rd, as);
        exp_rd = 8'hA5;
        checks++;
        if (lat !== 3 || wlow !== 0 || bad) begin
            failures++;
            $display("FAIL a_read_timing: got lat=%0d wlow=%0d bad_ack=%0d expected 3 0 0", lat, wlow, bad);
        end
        checks++;
        if (rd !== 8'hA5) begin
            failures++;
            $display("FAIL a_read_data: got %0h expected a5", rd);
        end
    endtask

    task automatic test_contention();
        int n = 0;
        int prev = 0;
        bit pb;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        exp_rd = 8'h00;
        a_req = 1'b1; a_we = 1'($urandom); a_addr = 20'($urandom_range(0, 7)); a_wdata = 8'($urandom);
        b_req = 1'b1; b_we = 1'($urandom); b_addr = 20'($urandom_range(0, 7)); b_wdata = 8'($urandom);
        for (int c = 0; c < 60 && n < 4; c++) begin
            @(negedge clk);
            checks++;
            if (a_ack && b_ack) begin
                failures++;
                $display("FAIL ack_overlap: got a_ack=1 b_ack=1 expected at most one");
            end
            if (a_ack || b_ack) begin
                pb = b_ack;
                checks++;
                if (pb !== 1'(n % 2)) begin
                    failures++;
                    $display("FAIL rr_order: grant %0d got port %0d expected %0d", n, pb, n % 2);
                end
                if (n > 0) begin
                    checks++;
                    if (c - prev !== 4) begin
                        failures++;
                        $display("FAIL rr_spacing: got %0d cycles expected 4", c - prev);
                    end
                end
                prev = c;
                if (pb ? b_we : a_we) ref_mem[int'(pb ? b_addr : a_addr)] = pb ? b_wdata : a_wdata;
                else exp_rd = ref_rd(pb ? b_addr : a_addr);
                checks++;
                if (rdata !== exp_rd) begin
                    failures++;
                    $display("FAIL rr_rdata: grant %0d got %0h expected %0h", n, rdata, exp_rd);
                end
                if (pb) begin
                    b_we = 1'($urandom); b_addr = 20'($urandom_range(0, 7)); b_wdata = 8'($urandom);
                end else begin
                    a_we = 1'($urandom); a_addr = 20'($urandom_range(0, 7)); a_wdata = 8'($urandom);
                end
                n++;
            end
        end
        checks++;
        if (n !== 4) begin
            failures++;
            $display("FAIL rr_timeout: got %0d acks expected 4", n);
        end
        a_req = 1'b0; b_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_full_addr();
        int lat, wlow; bit oe_wr, bad; logic [7:0] rd; logic [19:0] as;
        run_access(1'b1, 1'b1, 20'hFFFFF, 8'h3C, lat, wlow, oe_wr, bad, rd, as);
        ref_mem[32'hFFFFF] = 8'h3C;
        checks++;
        if (lat !== 3 || wlow !== 1 || as !== 20'hFFFFF || bad) begin
            failures++;
            $display("FAIL b_full_write: got lat=%0d wlow=%0d addr=%0h bad_ack=%0d expected 3 1 fffff 0", lat, wlow, as, bad);
        end
        run_access(1'b0, 1'b0, 20'hFFFFF, 8'h00, lat, wlow, oe_wr, bad, rd, as);
        exp_rd = 8'h3C;
        checks++;
        if (rd !== 8'h3C || as !== 20'hFFFFF) begin
            failures++;
            $display("FAIL a_full_read: got data=%0h addr=%0h expected 3c fffff", rd, as);
        end
    endtask

    task automatic test_addr_change();
        int lat, wlow; bit oe_wr, bad; logic [7:0] rd; logic [19:0] as;
        logic [7:0] other = ref_rd(20'h54321);
        a_req = 1'b1; a_we = 1'b1; a_addr = 20'h12345; a_wdata = 8'h77;
        @(negedge clk);
        a_addr = 20'h54321; a_wdata = 8'h99; a_we = 1'b0;
        @(negedge clk);
        checks++;
        if (ram_addr !== 20'h12345 || ram_wdata !== 8'h77 || ram_w_n !== 1'b0) begin
            failures++;
            $display("FAIL latch_hold: got addr=%0h wdata=%0h w_n=%0b expected 12345 77 0", ram_addr, ram_wdata, ram_w_n);
        end
        @(negedge clk);
        checks++;
        if (a_ack !== 1'b1 || ram_addr !== 20'h12345) begin
            failures++;
            $display("FAIL latch_ack: got ack=%0b addr=%0h expected 1 12345", a_ack, ram_addr);
        end
        a_req = 1'b0;
        @(negedge clk);
        ref_mem[32'h12345] = 8'h77;
        run_access(1'b0, 1'b0, 20'h12345, 8'h00, lat, wlow, oe_wr, bad, rd, as);
        exp_rd = 8'h77;
        checks++;
        if (rd !== 8'h77) begin
            failures++;
            $display("FAIL latch_orig_addr: got %0h expected 77", rd);
        end
        run_access(1'b1, 1'b0, 20'h54321, 8'h00, lat, wlow, oe_wr, bad, rd, as);
        exp_rd = other;
        checks++;
        if (rd !== other) begin
            failures++;
            $display("FAIL latch_other_addr: got %0h expected %0h", rd, other);
        end
    endtask

    task automatic test_reset_mid_write();
        int lat, wlow; bit oe_wr, bad; logic [7:0] rd; logic [19:0] as;
        logic [7:0]  v0 = 8'($urandom);
        logic [19:0] z  = 20'h0BEEF;
        run_access(1'b0, 1'b1, z, v0, lat, wlow, oe_wr, bad, rd, as);
        ref_mem[int'(z)] = v0;
        a_req = 1'b1; a_we = 1'b1; a_addr = z; a_wdata = ~v0;
        @(negedge clk);
        checks++;
        if (ram_cs_n !== 1'b0 || ram_w_n !== 1'b1) begin
            failures++;
            $display("FAIL mid_setup: got cs_n=%0b w_n=%0b expected 0 1", ram_cs_n, ram_w_n);
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({ram_cs_n, ram_oe_n, ram_w_n, a_ack, b_ack, busy} !== 6'b111000 || rdata !== 8'h00) begin
            failures++;
            $display("FAIL mid_reset: got ctrl=%b rdata=%0h expected 111000 0",
                     {ram_cs_n, ram_oe_n, ram_w_n, a_ack, b_ack, busy}, rdata);
        end
        reset = 1'b0; a_req = 1'b0;
        exp_rd = 8'h00;
        @(negedge clk);
        run_access(1'b1, 1'b0, z, 8'h00, lat, wlow, oe_wr, bad, rd, as);
        exp_rd = v0;
        checks++;
        if (rd !== v0 || bad) begin
            failures++;
            $display("FAIL mid_reset_prior: got %0h bad_ack=%0d expected %0h 0", rd, bad, v0);
        end
    endtask

    task automatic test_random();
        int lat, wlow; bit oe_wr, bad; logic [7:0] rd; logic [19:0] as;
        bit pb, we; logic [19:0] addr; logic [7:0] wd;
        for (int i = 0; i < 24; i++) begin
            pb   = 1'($urandom);
            we   = 1'($urandom);
            addr = (20'($urandom_range(0, 15)) << 16) | 20'($urandom_range(0, 3));
            wd   = 8'($urandom);
            run_access(pb, we, addr, wd, lat, wlow, oe_wr, bad, rd, as);
            if (we) ref_mem[int'(addr)] = wd;
            else exp_rd = ref_rd(addr);
            checks++;
            if (lat !== 3 || wlow !== int'(we) || oe_wr || bad || as !== addr) begin
                failures++;
                $display("FAIL rand_timing[%0d]: got lat=%0d wlow=%0d oe_wr=%0d bad_ack=%0d addr=%0h expected 3 %0d 0 0 %0h",
                         i, lat, wlow, oe_wr, bad, as, we, addr);
            end
            checks++;
            if (rd !== exp_rd) begin
                failures++;
                $display("FAIL rand_rdata[%0d]: got %0h expected %0h", i, rd, exp_rd);
            end
        end
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_a_write_read();
        test_contention();
        test_full_addr();
        test_addr_change();
        test_reset_mid_write();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
